// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receive path.
package uart_pkg;

    // Receiver FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Parity modes: the value is the parity seed XORed into the check.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Ceiling log2 for sizing counters; returns at least 1.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; both stages preset so the output is defined out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with configurable width, stop length, ratio and parity.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int OVS        = 16,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            parity_err,
    output logic            frame_err
);

    localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int SW   = clog2(SMAX);
    localparam int NW   = clog2(DBIT);

    localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    localparam logic          PAR_ON = (PARITY_EN != 0);
    localparam logic          SEED   = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    logic            rx_s;
    state_t          state, state_next;
    logic [SW-1:0]   s, s_next;
    logic [NW-1:0]   n, n_next;
    logic [DBIT-1:0] shreg, shreg_next;
    logic            par_acc, par_acc_next;
    logic            perr, perr_next;
    logic [DBIT-1:0] dout_next;
    logic            done_next, parity_err_next, frame_err_next;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // State, counters, datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            shreg        <= '0;
            par_acc      <= 1'b0;
            perr         <= 1'b0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_next;
            s            <= s_next;
            n            <= n_next;
            shreg        <= shreg_next;
            par_acc      <= par_acc_next;
            perr         <= perr_next;
            dout         <= dout_next;
            rx_done_tick <= done_next;
            parity_err   <= parity_err_next;
            frame_err    <= frame_err_next;
        end
    end

    // Next-state logic: mid-bit sampling, glitch rejection on the start bit.
    always_comb begin
        state_next      = state;
        s_next          = s;
        n_next          = n;
        shreg_next      = shreg;
        par_acc_next    = par_acc;
        perr_next       = perr;
        dout_next       = dout;
        done_next       = 1'b0;
        parity_err_next = parity_err;
        frame_err_next  = frame_err;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == S_HALF) begin
                        s_next = '0;
                        if (!rx_s) begin
                            state_next   = DATA;
                            n_next       = '0;
                            par_acc_next = 1'b0;
                            perr_next    = 1'b0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == S_BIT) begin
                        s_next       = '0;
                        shreg_next   = {rx_s, shreg[DBIT-1:1]};
                        par_acc_next = par_acc ^ rx_s;
                        if (n == N_LAST) begin
                            state_next = PAR_ON ? PARITY : STOP;
                        end else begin
                            n_next = n + NW'(1);
                        end
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s == S_BIT) begin
                        s_next     = '0;
                        perr_next  = rx_s ^ par_acc ^ SEED;
                        state_next = STOP;
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == S_STOP) begin
                        s_next          = '0;
                        state_next      = IDLE;
                        done_next       = 1'b1;
                        dout_next       = shreg;
                        parity_err_next = PAR_ON ? perr : 1'b0;
                        frame_err_next  = ~rx_s;
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                s_next     = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three configurations driven from directed frames.
module tb_uart_rx_cfg;

    localparam int BT = 64;  // clocks per bit: OVS 16 x s_tick every 4 clocks

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic [2:0] rxv = 3'b111;

    logic [7:0] dout_a, dout_b;
    logic [6:0] dout_p;
    logic       done_a, done_p, done_b;
    logic       pe_a, pe_p, pe_b;
    logic       fe_a, fe_p, fe_b;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   t_start [3];
    int   last_pulse [3];
    int   prev_pulse [3];
    int   npulse [3];
    exp_t q [3][$];

    uart_rx_cfg u_a (
        .clock(clock), .reset(reset), .rx(rxv[0]), .s_tick(s_tick),
        .dout(dout_a), .rx_done_tick(done_a), .parity_err(pe_a), .frame_err(fe_a)
    );

    uart_rx_cfg #(.DBIT(7), .PARITY_EN(1), .PARITY_ODD(0)) u_p (
        .clock(clock), .reset(reset), .rx(rxv[1]), .s_tick(s_tick),
        .dout(dout_p), .rx_done_tick(done_p), .parity_err(pe_p), .frame_err(fe_p)
    );

    uart_rx_cfg #(.SB_TICK(32)) u_b (
        .clock(clock), .reset(reset), .rx(rxv[2]), .s_tick(s_tick),
        .dout(dout_b), .rx_done_tick(done_b), .parity_err(pe_b), .frame_err(fe_b)
    );

    initial forever #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        int tcnt;
        tcnt = 0;
        forever begin
            @(negedge clock);
            tcnt   = (tcnt + 1) % 4;
            s_tick = (tcnt == 0);
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic handle(input int id, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        if (q[id].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse dut=%0d actual dout=%h required=no pulse", id, d);
        end else begin
            e = q[id].pop_front();
            chk($sformatf("dout_dut%0d", id), {7'd0, d}, {7'd0, e.d});
            chk($sformatf("parity_err_dut%0d", id), {15'd0, pe}, {15'd0, e.pe});
            chk($sformatf("frame_err_dut%0d", id), {15'd0, fe}, {15'd0, e.fe});
        end
        prev_pulse[id] = last_pulse[id];
        last_pulse[id] = cyc;
        npulse[id]++;
    endtask

    // Monitor: pops the scoreboard whenever any receiver reports a frame.
    initial forever begin
        @(posedge clock);
        #1;
        if (done_a) handle(0, {1'b0, dout_a}, pe_a, fe_a);
        if (done_p) handle(1, {2'b00, dout_p}, pe_p, fe_p);
        if (done_b) handle(2, {1'b0, dout_b}, pe_b, fe_b);
    end

    task automatic expect_frame(input int id, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        q[id].push_back(e);
    endtask

    task automatic drive(input int id, input logic b, input int nclk);
        rxv[id] = b;
        repeat (nclk) @(negedge clock);
    endtask

    task automatic send_frame(input int id, input logic [8:0] data, input int nbits,
                              input bit has_par, input logic pbit,
                              input int stop_low, input int stop_high);
        t_start[id] = cyc;
        drive(id, 1'b0, BT);
        for (int i = 0; i < nbits; i++) drive(id, data[i], BT);
        if (has_par) drive(id, pbit, BT);
        if (stop_low > 0) drive(id, 1'b0, stop_low);
        drive(id, 1'b1, stop_high);
    endtask

    initial begin
        int np;
        for (int i = 0; i < 3; i++) begin
            t_start[i] = 0; last_pulse[i] = 0; prev_pulse[i] = 0; npulse[i] = 0;
        end
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Reset state of every instance
        chk("reset_dout_a", {8'd0, dout_a}, 16'h0000);
        chk("reset_flags_a", {13'd0, done_a, pe_a, fe_a}, 16'h0000);
        chk("reset_dout_p", {9'd0, dout_p}, 16'h0000);
        chk("reset_flags_p", {13'd0, done_p, pe_p, fe_p}, 16'h0000);
        chk("reset_dout_b", {8'd0, dout_b}, 16'h0000);
        chk("reset_flags_b", {13'd0, done_b, pe_b, fe_b}, 16'h0000);

        // 0xA5 8N1, pulse about 9.5 bit times after the start edge
        expect_frame(0, 9'h0A5, 1'b0, 1'b0);
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 0, BT);
        repeat (BT) @(negedge clock);
        chk_rng("a5_latency", last_pulse[0] - t_start[0], 600, 616);

        // Short low glitch is rejected
        np = npulse[0];
        drive(0, 1'b0, 12);
        drive(0, 1'b1, 3 * BT);
        chk("glitch_no_pulse", 16'(npulse[0] - np), 16'd0);
        chk("glitch_dout_hold", {8'd0, dout_a}, 16'h00A5);

        // Parity config, DBIT=7 even: 0x41 has two ones -> parity bit 0
        expect_frame(1, 9'h041, 1'b0, 1'b0);
        send_frame(1, 9'h041, 7, 1'b1, 1'b0, 0, BT);
        drive(1, 1'b1, BT);
        expect_frame(1, 9'h041, 1'b1, 1'b0);
        send_frame(1, 9'h041, 7, 1'b1, 1'b1, 0, BT);
        drive(1, 1'b1, BT);

        // Stop bit low -> framing error, then a clean frame clears it
        expect_frame(0, 9'h03C, 1'b0, 1'b1);
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 40, 24);
        drive(0, 1'b1, 2 * BT);
        expect_frame(0, 9'h055, 1'b0, 1'b0);
        send_frame(0, 9'h055, 8, 1'b0, 1'b0, 0, BT);
        drive(0, 1'b1, BT);

        // Back-to-back frames with two stop bits
        expect_frame(2, 9'h000, 1'b0, 1'b0);
        expect_frame(2, 9'h0FF, 1'b0, 1'b0);
        send_frame(2, 9'h000, 8, 1'b0, 1'b0, 0, 2 * BT);
        send_frame(2, 9'h0FF, 8, 1'b0, 1'b0, 0, 2 * BT);
        drive(2, 1'b1, BT);
        chk("b2b_pulses", 16'(npulse[2]), 16'd2);
        chk_rng("b2b_spacing", last_pulse[2] - prev_pulse[2], 696, 712);

        // Reset during data bit 4 of 0x96 aborts the frame
        np = npulse[0];
        drive(0, 1'b0, BT);
        for (int i = 0; i < 4; i++) drive(0, logic'((8'h96 >> i) & 8'h01), BT);
        drive(0, 1'b1, 30);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        drive(0, 1'b1, 12 * BT);
        chk("midreset_no_pulse", 16'(npulse[0] - np), 16'd0);
        chk("midreset_dout", {8'd0, dout_a}, 16'h0000);
        chk("midreset_flags", {14'd0, pe_a, fe_a}, 16'h0000);
        expect_frame(0, 9'h096, 1'b0, 1'b0);
        send_frame(0, 9'h096, 8, 1'b0, 1'b0, 0, BT);
        drive(0, 1'b1, 2 * BT);

        // Every expected frame must have been delivered
        for (int i = 0; i < 3; i++)
            chk($sformatf("scoreboard_empty_dut%0d", i), 16'(q[i].size()), 16'd0);
        chk("pulse_count_a", 16'(npulse[0]), 16'd4);
        chk("pulse_count_p", 16'(npulse[1]), 16'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
